// File: rtl/vec_issue_pkg.sv
// Shared types for the vector issue controller.
//   VEC_XLEN      : width of instruction/operand fields carried in a queue entry
//   vec_entry_t   : one queued vector instruction with its forwarded operands
//   issue_state_e : issue FSM states
package vec_issue_pkg;

    localparam int VEC_XLEN = 32;

    typedef struct packed {
        logic [VEC_XLEN-1:0] inst;
        logic [VEC_XLEN-1:0] rs1;
        logic [VEC_XLEN-1:0] rs2;
        logic                needs_wb;
    } vec_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } issue_state_e;

endpackage

// File: rtl/vec_issue_fifo.sv
// Instruction queue for the vector issue controller.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_entry (ignored when full unless popping in the same cycle)
//   pop       : retire head entry (ignored when empty)
//   flush     : discard every entry; wins over push/pop
//   wr_entry  : entry to write
//   head      : oldest entry
//   full/empty/count : occupancy
module vec_issue_fifo
    import vec_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  vec_entry_t               wr_entry,
    output vec_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    vec_entry_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so the increment wraps naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && full && !pop)) else $error("vec_issue_fifo: push while full");
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Issue controller between the scalar core and the vector processor.
// Queues vector instructions with forwarded rs1/rs2, issues them one at a time
// over inst_valid/vec_pro_ready, waits for vec_pro_ack, returns results to the
// scalar writeback path and stalls the scalar core when full or draining.
//   clk, rst                     : clock, synchronous active-high reset
//   sc_vec_valid/inst/rs1/rs2    : scalar offer of a vector instruction
//   sc_needs_wb                  : result returns to scalar rd
//   sc_fence                     : drain all vector work before accepting more
//   sc_ready                     : offer accepted this cycle (low = stall)
//   inst_valid/inst_out/rs1_out/rs2_out, vec_pro_ready : issue handshake
//   vec_pro_ack/vec_error/csr_out: completion of outstanding instruction
//   wb_valid/wb_data             : one-cycle writeback pulse to scalar
//   err_sticky/err_clr           : sticky error flag and its clear
//   busy                         : queue non-empty or instruction in flight
// XLEN must equal VEC_XLEN from vec_issue_pkg.
module vec_issue_ctrl
    import vec_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = VEC_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sc_vec_valid,
    input  logic [XLEN-1:0] sc_vec_inst,
    input  logic [XLEN-1:0] sc_rs1,
    input  logic [XLEN-1:0] sc_rs2,
    input  logic            sc_needs_wb,
    input  logic            sc_fence,
    output logic            sc_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    input  logic            vec_pro_ready,
    input  logic            vec_pro_ack,
    input  logic            vec_error,
    input  logic [XLEN-1:0] csr_out,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic            err_sticky,
    input  logic            err_clr,
    output logic            busy
);

    issue_state_e               state;
    logic                       draining;
    logic                       pending_wb;
    vec_entry_t                 new_e;
    vec_entry_t                 head;
    vec_entry_t                 next_e;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       push;
    logic                       pop;
    logic                       err_ack;
    logic                       have_work;

    assign new_e     = '{inst: sc_vec_inst, rs1: sc_rs1, rs2: sc_rs2, needs_wb: sc_needs_wb};
    assign sc_ready  = !full && !draining;
    assign err_ack   = (state == WAIT_ACK) && vec_pro_ack && vec_error;
    // An erroring ack flushes the queue, so a push in that cycle is dropped.
    assign push      = sc_vec_valid && sc_ready && !err_ack;
    assign pop       = (state == ISSUE) && inst_valid && vec_pro_ready;
    assign have_work = !empty || push;
    // With an empty queue the entry being pushed this cycle is issued directly,
    // so inst_valid rises the cycle after the push.
    assign next_e    = empty ? new_e : head;
    assign busy      = (count != '0) || (state != IDLE);

    vec_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (err_ack),
        .wr_entry (new_e),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            rs1_out    <= '0;
            rs2_out    <= '0;
            pending_wb <= 1'b0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            err_sticky <= 1'b0;
            draining   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (have_work) begin
                        state      <= ISSUE;
                        inst_valid <= 1'b1;
                        inst_out   <= next_e.inst;
                        rs1_out    <= next_e.rs1;
                        rs2_out    <= next_e.rs2;
                    end
                end
                ISSUE: begin
                    if (vec_pro_ready) begin
                        state      <= WAIT_ACK;
                        inst_valid <= 1'b0;
                        pending_wb <= head.needs_wb;
                    end
                end
                WAIT_ACK: begin
                    if (vec_pro_ack) begin
                        wb_valid <= pending_wb;
                        if (pending_wb) wb_data <= csr_out;
                        if (vec_error || !have_work) begin
                            state <= IDLE;
                        end else begin
                            state      <= ISSUE;
                            inst_valid <= 1'b1;
                            inst_out   <= next_e.inst;
                            rs1_out    <= next_e.rs1;
                            rs2_out    <= next_e.rs2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A new error beats a same-cycle clear.
            if (err_ack)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;

            if (sc_fence)                                   draining <= 1'b1;
            else if (draining && empty && state == IDLE)    draining <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(pop && vec_pro_ack)) else $error("vec_issue_ctrl: ack during issue handshake");
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
module tb_vec_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sc_vec_valid;
    logic [31:0] sc_vec_inst, sc_rs1, sc_rs2;
    logic        sc_needs_wb, sc_fence, sc_ready;
    logic        inst_valid;
    logic [31:0] inst_out, rs1_out, rs2_out;
    logic        vec_pro_ready, vec_pro_ack, vec_error;
    logic [31:0] csr_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        err_sticky, err_clr, busy;

    int checks = 0;
    int errors = 0;

    vec_issue_ctrl #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .sc_vec_valid(sc_vec_valid), .sc_vec_inst(sc_vec_inst), .sc_rs1(sc_rs1), .sc_rs2(sc_rs2),
        .sc_needs_wb(sc_needs_wb), .sc_fence(sc_fence), .sc_ready(sc_ready),
        .inst_valid(inst_valid), .inst_out(inst_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .vec_pro_ready(vec_pro_ready), .vec_pro_ack(vec_pro_ack), .vec_error(vec_error),
        .csr_out(csr_out), .wb_valid(wb_valid), .wb_data(wb_data),
        .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic        nwb;
        logic        rdy;
        logic        ack;
        logic [31:0] csr;
        logic        e_rdy;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_rs1;
        logic        e_wb;
        logic [31:0] e_wbd;
        logic        e_busy;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sc_vec_valid = 0; sc_vec_inst = 0; sc_rs1 = 0; sc_rs2 = 0; sc_needs_wb = 0;
        sc_fence = 0; vec_pro_ready = 0; vec_pro_ack = 0; vec_error = 0; csr_out = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] rs1, input logic nwb);
        sc_vec_valid = 1; sc_vec_inst = inst; sc_rs1 = rs1; sc_rs2 = ~rs1; sc_needs_wb = nwb;
        step();
        sc_vec_valid = 0;
    endtask

    // Wait for the next issue, check it, accept it, ack it and check writeback.
    task automatic drain_one(input string nm, input logic [31:0] exp_inst, input logic [31:0] exp_rs1,
                             input logic exp_wb);
        int n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        chk1({nm, "_issued"}, inst_valid, 1'b1);
        chk32({nm, "_inst"}, inst_out, exp_inst);
        chk32({nm, "_rs1"}, rs1_out, exp_rs1);
        chk32({nm, "_rs2"}, rs2_out, ~exp_rs1);
        vec_pro_ready = 1;
        step();
        vec_pro_ready = 0;
        chk1({nm, "_waitack_iv"}, inst_valid, 1'b0);
        vec_pro_ack = 1; csr_out = exp_inst ^ 32'hA5A5_0000;
        step();
        vec_pro_ack = 0;
        chk1({nm, "_wb_valid"}, wb_valid, exp_wb);
        if (exp_wb) chk32({nm, "_wb_data"}, wb_data, exp_inst ^ 32'hA5A5_0000);
    endtask

    initial begin
        // v inst rs1 nwb rdy ack csr | e_rdy e_iv e_inst e_rs1 e_wb e_wbd e_busy
        tbl[0] = '{1, 32'h0200_7057, 32'd8, 1, 0, 0, 0,            1, 0, 0,            0,     0, 0,            0};
        tbl[1] = '{0, 0,             0,     0, 0, 0, 0,            1, 1, 32'h0200_7057, 32'd8, 0, 0,            1};
        tbl[2] = '{0, 0,             0,     0, 0, 0, 0,            1, 1, 32'h0200_7057, 32'd8, 0, 0,            1};
        tbl[3] = '{0, 0,             0,     0, 1, 0, 0,            1, 1, 32'h0200_7057, 32'd8, 0, 0,            1};
        tbl[4] = '{0, 0,             0,     0, 0, 0, 0,            1, 0, 0,            0,     0, 0,            1};
        tbl[5] = '{0, 0,             0,     0, 0, 0, 0,            1, 0, 0,            0,     0, 0,            1};
        tbl[6] = '{0, 0,             0,     0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0,            0,     0, 0,            1};
        tbl[7] = '{0, 0,             0,     0, 0, 0, 0,            1, 0, 0,            0,     1, 32'hDEAD_BEEF, 0};
        tbl[8] = '{0, 0,             0,     0, 0, 0, 0,            1, 0, 0,            0,     0, 0,            0};

        do_reset();
        chk1("reset_err_sticky", err_sticky, 1'b0);
        chk32("reset_inst_out", inst_out, 32'h0);
        chk32("reset_wb_data", wb_data, 32'h0);

        // Test 1: single instruction, table-driven
        for (int i = 0; i < 9; i++) begin
            sc_vec_valid = tbl[i].v; sc_vec_inst = tbl[i].inst; sc_rs1 = tbl[i].rs1; sc_rs2 = 0;
            sc_needs_wb = tbl[i].nwb; vec_pro_ready = tbl[i].rdy; vec_pro_ack = tbl[i].ack;
            csr_out = tbl[i].csr;
            chk1($sformatf("t1_c%0d_sc_ready", i), sc_ready, tbl[i].e_rdy);
            chk1($sformatf("t1_c%0d_inst_valid", i), inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk32($sformatf("t1_c%0d_inst_out", i), inst_out, tbl[i].e_inst);
                chk32($sformatf("t1_c%0d_rs1_out", i), rs1_out, tbl[i].e_rs1);
            end
            chk1($sformatf("t1_c%0d_wb_valid", i), wb_valid, tbl[i].e_wb);
            if (tbl[i].e_wb) chk32($sformatf("t1_c%0d_wb_data", i), wb_data, tbl[i].e_wbd);
            chk1($sformatf("t1_c%0d_busy", i), busy, tbl[i].e_busy);
            step();
        end
        idle_inputs();

        // Test 2/3: five pushes into a 4-deep queue, pop while full with an offer pending
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("t2_ready_push%0d", i), sc_ready, 1'b1);
            push_one(32'h100 + i, i, 0);
        end
        sc_vec_valid = 1; sc_vec_inst = 32'h104; sc_rs1 = 4; sc_rs2 = ~32'd4; sc_needs_wb = 0;
        chk1("t2_full_stall", sc_ready, 1'b0);
        step();
        chk1("t2_full_stall2", sc_ready, 1'b0);
        chk32("t2_head_presented", inst_out, 32'h100);
        vec_pro_ready = 1;
        step();
        vec_pro_ready = 0;
        chk1("t2_ready_after_pop", sc_ready, 1'b1);
        step();
        sc_vec_valid = 0;
        chk1("t2_full_again", sc_ready, 1'b0);
        chk1("t2_waitack_iv", inst_valid, 1'b0);
        vec_pro_ack = 1;
        step();
        vec_pro_ack = 0;
        for (int i = 1; i < 5; i++) drain_one($sformatf("t2_drain%0d", i), 32'h100 + i, i, 0);
        chk1("t2_idle_busy", busy, 1'b0);

        // Test 4: error on first ack flushes the queue and drops a same-cycle push
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'h200 + i, 32'h20 + i, 0);
        chk1("t4_iv", inst_valid, 1'b1);
        vec_pro_ready = 1;
        step();
        vec_pro_ready = 0;
        vec_pro_ack = 1; vec_error = 1;
        sc_vec_valid = 1; sc_vec_inst = 32'h2FF; sc_needs_wb = 0;
        step();
        idle_inputs();
        chk1("t4_err_sticky", err_sticky, 1'b1);
        chk1("t4_busy", busy, 1'b0);
        chk1("t4_wb_none", wb_valid, 1'b0);
        chk1("t4_sc_ready", sc_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk1($sformatf("t4_no_issue%0d", i), inst_valid, 1'b0);
            chk1($sformatf("t4_still_idle%0d", i), busy, 1'b0);
        end
        err_clr = 1;
        step();
        err_clr = 0;
        chk1("t4_err_clr", err_sticky, 1'b0);

        // Test 5: fence with two queued, then fence with nothing pending
        do_reset();
        push_one(32'h300, 32'h30, 1);
        push_one(32'h301, 32'h31, 0);
        sc_fence = 1;
        step();
        sc_fence = 0;
        chk1("t5_stall", sc_ready, 1'b0);
        drain_one("t5_c0", 32'h300, 32'h30, 1);
        chk1("t5_stall_mid", sc_ready, 1'b0);
        drain_one("t5_c1", 32'h301, 32'h31, 0);
        chk1("t5_stall_at_idle", sc_ready, 1'b0);
        chk1("t5_busy_idle", busy, 1'b0);
        step();
        chk1("t5_ready_after", sc_ready, 1'b1);
        sc_fence = 1;
        step();
        sc_fence = 0;
        chk1("t5_empty_fence_stall", sc_ready, 1'b0);
        step();
        chk1("t5_empty_fence_release", sc_ready, 1'b1);

        // Test 6: reset while waiting for ack with two queued; late ack ignored
        do_reset();
        for (int i = 0; i < 3; i++) push_one(32'h400 + i, 32'h40 + i, 1);
        vec_pro_ready = 1;
        step();
        vec_pro_ready = 0;
        chk1("t6_in_waitack", busy, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk1("t6_sc_ready", sc_ready, 1'b1);
        chk1("t6_inst_valid", inst_valid, 1'b0);
        chk32("t6_inst_out", inst_out, 32'h0);
        chk32("t6_rs1_out", rs1_out, 32'h0);
        chk32("t6_rs2_out", rs2_out, 32'h0);
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_err", err_sticky, 1'b0);
        vec_pro_ack = 1; csr_out = 32'h1234_5678;
        step();
        vec_pro_ack = 0;
        chk1("t6_late_ack_wb", wb_valid, 1'b0);
        chk32("t6_late_ack_wbd", wb_data, 32'h0);
        chk1("t6_late_ack_busy", busy, 1'b0);
        step();
        chk1("t6_no_issue", inst_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
